clock_display_scan: RTL and testbench

- Reads the binary time (hours/minutes/seconds) produced by the digital clock core and drives a 6-digit multiplexed, active-low 7-segment display (HH MM SS).
- Uses a sequential binary-to-BCD converter shared across the three fields.
- Commits all six digits atomically, so a digit from one second is never shown alongside digits from another.
- Sits between the clock core outputs and the board display pins.

---
 rtl/clock_disp_pkg.sv | 29 ++
 rtl/bin2bcd_seq.sv | 53 +++++
 rtl/clock_display_scan.sv | 160 ++++++++++++++++
 tb/tb_clock_display_scan.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/clock_disp_pkg.sv
// Shared types and constants for the multiplexed HH:MM:SS 7-segment display driver.
package clock_disp_pkg;

  localparam int         NUM_DIGITS = 6;
  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam logic [5:0] AN_OFF     = 6'h3F;

  localparam logic [2:0] IDX_COLON_A = 3'd2;
  localparam logic [2:0] IDX_COLON_B = 3'd4;
  localparam logic [2:0] IDX_HR_TENS = 3'd5;

  typedef enum logic [2:0] {IDLE, CONV_S, CONV_M, CONV_H, COMMIT} conv_state_t;

  typedef struct packed {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
  } hms_t;

  // Active-low {g,f,e,d,c,b,a}; entry [0] is digit 0.
  localparam logic [9:0][6:0] SEG_TAB = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    seg_decode = (d <= 4'd9) ? SEG_TAB[d] : SEG_OFF;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 6-bit double-dabble: load on start, six shift/add-3 steps, one-cycle done.
module bin2bcd_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] bin,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [5:0] sh;
  logic [7:0] bcd;
  logic [2:0] step;
  logic       busy;

  function automatic logic [7:0] add3(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if (r[3:0] >= 4'd5) r[3:0] = r[3:0] + 4'd3;
    if (r[7:4] >= 4'd5) r[7:4] = r[7:4] + 4'd3;
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh   <= '0;
      bcd  <= '0;
      step <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sh   <= bin;
        bcd  <= '0;
        step <= '0;
        busy <= 1'b1;
      end else if (busy) begin
        {bcd, sh} <= {add3(bcd), sh} << 1;
        step      <= step + 3'd1;
        if (step == 3'd5) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign tens = bcd[7:4];
  assign ones = bcd[3:0];

endmodule

// File: rtl/clock_display_scan.sv
// Converts the clock core's binary H/M/S to BCD with one shared converter and
// scans the six digits onto an active-low multiplexed 7-segment display.
module clock_display_scan
  import clock_disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  input  logic [4:0] hours,
  input  logic       blank,
  output logic [5:0] digit_an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       bcd_valid
);

  localparam int PW = $clog2(SCAN_DIV);

  conv_state_t state, state_nxt;
  hms_t        cur, snap;
  logic        snap_en, start_nxt, stage_en, commit;

  logic       conv_start, conv_done;
  logic [5:0] conv_bin;
  logic [3:0] conv_tens, conv_ones;

  logic [NUM_DIGITS-1:0][3:0] stage, disp, disp_nxt;
  logic                       valid_q, valid_nxt;

  logic [PW-1:0] presc, presc_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [3:0]    cur_digit;
  logic [5:0]    an_q;
  logic [6:0]    seg_q;
  logic          dp_q;

  assign cur = {hours, minutes, seconds};

  always_comb begin
    case (state)
      CONV_M:  conv_bin = snap.m;
      CONV_H:  conv_bin = {1'b0, snap.h};
      default: conv_bin = snap.s;
    endcase
  end

  bin2bcd_seq u_b2b (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (conv_bin),
    .done  (conv_done),
    .tens  (conv_tens),
    .ones  (conv_ones)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    snap_en   = 1'b0;
    start_nxt = 1'b0;
    stage_en  = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: if (!valid_q || cur != snap) begin
        snap_en   = 1'b1;
        start_nxt = 1'b1;
        state_nxt = CONV_S;
      end
      CONV_S: if (conv_done) begin
        stage_en  = 1'b1;
        start_nxt = 1'b1;
        state_nxt = CONV_M;
      end
      CONV_M: if (conv_done) begin
        stage_en  = 1'b1;
        start_nxt = 1'b1;
        state_nxt = CONV_H;
      end
      CONV_H: if (conv_done) begin
        stage_en  = 1'b1;
        state_nxt = COMMIT;
      end
      COMMIT: begin
        commit    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Digits land in staging field by field and only reach the display on commit,
  // so the visible six digits always come from one snapshot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap       <= '0;
      stage      <= '0;
      disp       <= '0;
      valid_q    <= 1'b0;
      conv_start <= 1'b0;
    end else begin
      conv_start <= start_nxt;
      if (snap_en) snap <= cur;
      if (stage_en) begin
        case (state)
          CONV_S: begin stage[1] <= conv_tens; stage[0] <= conv_ones; end
          CONV_M: begin stage[3] <= conv_tens; stage[2] <= conv_ones; end
          CONV_H: begin stage[5] <= conv_tens; stage[4] <= conv_ones; end
          default: ;
        endcase
      end
      disp    <= disp_nxt;
      valid_q <= valid_nxt;
    end
  end

  always_comb begin
    presc_nxt = (presc == PW'(SCAN_DIV - 1)) ? '0 : presc + 1'b1;
    idx_nxt   = idx;
    if (presc == PW'(SCAN_DIV - 1)) idx_nxt = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    disp_nxt  = commit ? stage : disp;
    valid_nxt = valid_q | commit;
    cur_digit = disp_nxt[idx_nxt];
  end

  // Output registers are fed from next-state values so they line up with the
  // scan index and committed digits in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      idx   <= '0;
      an_q  <= AN_OFF;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
    end else begin
      presc <= presc_nxt;
      idx   <= idx_nxt;
      an_q  <= ~(6'b1 << idx_nxt);
      if (!valid_nxt || (idx_nxt == IDX_HR_TENS && cur_digit == 4'd0))
        seg_q <= SEG_OFF;
      else
        seg_q <= seg_decode(cur_digit);
      dp_q  <= !(valid_nxt && (idx_nxt == IDX_COLON_A || idx_nxt == IDX_COLON_B)
                 && !disp_nxt[0][0]);
    end
  end

  assign digit_an  = blank ? AN_OFF  : an_q;
  assign seg       = blank ? SEG_OFF : seg_q;
  assign dp        = blank ? 1'b1    : dp_q;
  assign bcd_valid = valid_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Scoreboard bench: stimulus queues per-cycle expected display state, a
// negedge monitor pops and compares entries whose cycle has arrived.
module tb_clock_display_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] seconds, minutes;
  logic [4:0] hours;
  logic       blank;
  logic [5:0] digit_an;
  logic [6:0] seg;
  logic       dp, bcd_valid;

  always #5 clk = ~clk;

  clock_display_scan #(.SCAN_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .seconds   (seconds),
    .minutes   (minutes),
    .hours     (hours),
    .blank     (blank),
    .digit_an  (digit_an),
    .seg       (seg),
    .dp        (dp),
    .bcd_valid (bcd_valid)
  );

  // Edges since reset release; cycle k shows the state after edge k.
  int cyc;
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    int         at;
    int         tid;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       v;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic push_seq(input int tid, input int k0, input int k1, input int h,
                          input int m, input int s, input bit v, input bit b);
    for (int k = k0; k <= k1; k++) begin
      exp_t e;
      int   d[6];
      int   idx;
      d[0] = s % 10; d[1] = s / 10; d[2] = m % 10;
      d[3] = m / 10; d[4] = h % 10; d[5] = h / 10;
      idx   = (k / 4) % 6;
      e.at  = k;
      e.tid = tid;
      e.v   = v;
      e.an  = ~(6'b1 << idx);
      e.seg = 7'h7F;
      e.dp  = 1'b1;
      if (b) begin
        e.an = 6'h3F;
      end else if (v) begin
        e.seg = (idx == 5 && d[5] == 0) ? 7'h7F : seg_of(d[idx]);
        e.dp  = ((idx == 2 || idx == 4) && (s % 2 == 0)) ? 1'b0 : 1'b1;
      end
      sb.push_back(e);
    end
  endtask

  task automatic push_rst(input int tid);
    exp_t e;
    e.at = 0; e.tid = tid; e.an = 6'h3F; e.seg = 7'h7F; e.dp = 1'b1; e.v = 1'b0;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      me = sb.pop_front();
      n_cmp++;
      if (me.at != cyc || digit_an !== me.an || seg !== me.seg || dp !== me.dp ||
          bcd_valid !== me.v) begin
        n_bad++;
        $display("FAIL t%0d cyc=%0d (due %0d): got an=%b seg=%h dp=%b v=%b, want an=%b seg=%h dp=%b v=%b",
                 me.tid, cyc, me.at, digit_an, seg, dp, bcd_valid, me.an, me.seg, me.dp, me.v);
      end
    end
  end

  task automatic drain(input int limit);
    int w = 0;
    while (sb.size() > 0 && w < limit) begin
      @(posedge clk); #1;
      w++;
    end
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d entries left, required 0", sb.size());
      $fatal(1, "scoreboard did not drain");
    end
  endtask

  initial begin
    int c;
    reset = 1'b0; blank = 1'b0;
    hours = 5'd12; minutes = 6'd34; seconds = 6'd56;
    push_rst(0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // First conversion 12:34:56, visible exactly at cycle 26; full scan after.
    push_seq(1, 1, 25, 12, 34, 56, 1'b0, 1'b0);
    push_seq(1, 26, 60, 12, 34, 56, 1'b1, 1'b0);
    drain(200);

    // Input change mid-conversion is held off until the next IDLE compare.
    c = cyc;
    hours = 5'd10; minutes = 6'd15; seconds = 6'd59;
    push_seq(2, c + 1, c + 25, 12, 34, 56, 1'b1, 1'b0);
    push_seq(2, c + 26, c + 51, 10, 15, 59, 1'b1, 1'b0);
    push_seq(2, c + 52, c + 60, 10, 16, 0, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1 minutes = 6'd16; seconds = 6'd0;
    drain(200);

    // Leading-zero hours tens, out-of-range minutes, odd seconds.
    c = cyc;
    hours = 5'd5; minutes = 6'd63; seconds = 6'd1;
    push_seq(3, c + 1, c + 25, 10, 16, 0, 1'b1, 1'b0);
    push_seq(3, c + 26, c + 50, 5, 63, 1, 1'b1, 1'b0);
    drain(200);

    // Blank mid-scan; scan phase continues underneath.
    c = cyc;
    blank = 1'b1;
    push_seq(4, c, c + 9, 5, 63, 1, 1'b1, 1'b1);
    push_seq(4, c + 10, c + 30, 5, 63, 1, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #1 blank = 1'b0;
    drain(200);

    // Reset between edges in the middle of a conversion, then a clean restart.
    hours = 5'd23; minutes = 6'd59; seconds = 6'd58;
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    push_rst(5);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    push_seq(6, 1, 25, 23, 59, 58, 1'b0, 1'b0);
    push_seq(6, 26, 40, 23, 59, 58, 1'b1, 1'b0);
    drain(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
